// File: rtl/id_hazard_stage.sv
// ID stage with load-use / branch-operand hazard stalls, forwarding selects,
// BEZ/BNEZ resolution in ID, and the ID/EX pipeline register.
module id_hazard_stage #(
  parameter int DATA_W   = 64,
  parameter int RADDR_W  = 5,
  parameter int IMM_W    = 16,
  parameter int OP_W     = 6,
  parameter int LOAD_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [OP_W-1:0]    id_op_code,
  input  logic [RADDR_W-1:0] id_rD,
  input  logic [RADDR_W-1:0] id_rA,
  input  logic [RADDR_W-1:0] id_rB,
  input  logic               id_rA_used,
  input  logic               id_rB_used,
  input  logic               id_wrEn,
  input  logic               id_memEn,
  input  logic               id_memwrEn,
  input  logic               id_bez,
  input  logic               id_bnez,
  input  logic [IMM_W-1:0]   id_imm_addr,
  input  logic [DATA_W-1:0]  id_rA_data,
  input  logic [DATA_W-1:0]  id_rB_data,
  input  logic [RADDR_W-1:0] mem_rD,
  input  logic               mem_wrEn,
  input  logic [RADDR_W-1:0] wb_rD,
  input  logic               wb_wrEn,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               id_stall,
  output logic               id_br_taken,
  output logic [IMM_W-1:0]   id_br_target,
  output logic               ex_valid,
  output logic [OP_W-1:0]    ex_op_code,
  output logic [RADDR_W-1:0] ex_rD,
  output logic               ex_wrEn,
  output logic               ex_memEn,
  output logic               ex_memwrEn,
  output logic [IMM_W-1:0]   ex_imm,
  output logic [DATA_W-1:0]  ex_rA_data,
  output logic [DATA_W-1:0]  ex_rB_data,
  output logic [1:0]         ex_fwd_A,
  output logic [1:0]         ex_fwd_B
);

  typedef enum logic {RUN, STALL} state_e;

  typedef struct packed {
    logic               valid;
    logic [OP_W-1:0]    op;
    logic [RADDR_W-1:0] rd;
    logic               wr;
    logic               mem;
    logic               memwr;
    logic [IMM_W-1:0]   imm;
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [1:0]         fa;
    logic [1:0]         fb;
  } id_ex_t;

  localparam logic [2:0] CNT_INIT = 3'(LOAD_LAT - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  id_ex_t      ex_q, ex_d;
  logic        ex_load, lu_haz, br_haz, stall, adv;
  logic [DATA_W-1:0] rbv;

  function automatic logic [1:0] fwd_sel(
    input logic               used,
    input logic [RADDR_W-1:0] r
  );
    if (!used)                        return 2'b00;
    else if (mem_wrEn && mem_rD == r) return 2'b01;
    else if (wb_wrEn && wb_rD == r)   return 2'b10;
    else                              return 2'b00;
  endfunction

  assign ex_load = ex_q.valid & ex_q.mem & ~ex_q.memwr & ex_q.wr;
  assign lu_haz  = ex_load & id_valid &
                   ((id_rA_used & (id_rA == ex_q.rd)) |
                    (id_rB_used & (id_rB == ex_q.rd)));
  // The branch compares rB in ID, so an EX-stage producer is too late.
  assign br_haz  = id_valid & (id_bez | id_bnez) &
                   ex_q.valid & ex_q.wr & (id_rB == ex_q.rd);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (lu_haz) begin
          stall   = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = (LOAD_LAT > 1) ? STALL : RUN;
        end else if (br_haz) begin
          stall = 1'b1;
        end
      end
      STALL: begin
        stall = 1'b1;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign id_stall = stall & ~reset;
  assign adv      = id_valid & ~stall;

  assign rbv = (wb_wrEn && wb_rD == id_rB) ? wb_data : id_rB_data;
  assign id_br_taken  = id_valid & ~stall & ~reset &
                        ((id_bez & (rbv == '0)) | (id_bnez & (rbv != '0)));
  assign id_br_target = id_imm_addr;

  always_comb begin
    ex_d       = '0;
    ex_d.valid = adv;
    ex_d.op    = id_op_code;
    ex_d.rd    = id_rD;
    ex_d.wr    = adv & id_wrEn;
    ex_d.mem   = adv & id_memEn;
    ex_d.memwr = adv & id_memwrEn;
    ex_d.imm   = id_imm_addr;
    ex_d.a     = id_rA_data;
    ex_d.b     = id_rB_data;
    ex_d.fa    = adv ? fwd_sel(id_rA_used, id_rA) : 2'b00;
    ex_d.fb    = adv ? fwd_sel(id_rB_used, id_rB) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      ex_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
    end
  end

  assign ex_valid   = ex_q.valid;
  assign ex_op_code = ex_q.op;
  assign ex_rD      = ex_q.rd;
  assign ex_wrEn    = ex_q.wr;
  assign ex_memEn   = ex_q.mem;
  assign ex_memwrEn = ex_q.memwr;
  assign ex_imm     = ex_q.imm;
  assign ex_rA_data = ex_q.a;
  assign ex_rB_data = ex_q.b;
  assign ex_fwd_A   = ex_q.fa;
  assign ex_fwd_B   = ex_q.fb;

endmodule

// File: tb/tb_id_hazard_stage.sv
// Scoreboard bench for id_hazard_stage: LOAD_LAT=1 and LOAD_LAT=3 instances
// share stimulus; a monitor checks whichever instance the current phase targets.
module tb_id_hazard_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [5:0]  id_op_code;
  logic [4:0]  id_rD, id_rA, id_rB;
  logic        id_rA_used, id_rB_used;
  logic        id_wrEn, id_memEn, id_memwrEn;
  logic        id_bez, id_bnez;
  logic [15:0] id_imm_addr;
  logic [63:0] id_rA_data, id_rB_data;
  logic [4:0]  mem_rD, wb_rD;
  logic        mem_wrEn, wb_wrEn;
  logic [63:0] wb_data;

  logic        s1, bt1, v1, w1, m1, mw1;
  logic [15:0] tg1, im1;
  logic [5:0]  op1;
  logic [4:0]  rd1;
  logic [63:0] ra1, rb1;
  logic [1:0]  fa1, fb1;

  logic        s3, bt3, v3, w3, m3, mw3;
  logic [15:0] tg3, im3;
  logic [5:0]  op3;
  logic [4:0]  rd3;
  logic [63:0] ra3, rb3;
  logic [1:0]  fa3, fb3;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic        w, m, mw;
    logic [15:0] imm;
    logic [63:0] a, b;
    logic [1:0]  fa, fb;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   phase  = 0;

  always #5 clk = ~clk;

  id_hazard_stage #(.LOAD_LAT(1)) u1 (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_op_code(id_op_code), .id_rD(id_rD), .id_rA(id_rA),
    .id_rB(id_rB), .id_rA_used(id_rA_used), .id_rB_used(id_rB_used),
    .id_wrEn(id_wrEn), .id_memEn(id_memEn), .id_memwrEn(id_memwrEn),
    .id_bez(id_bez), .id_bnez(id_bnez), .id_imm_addr(id_imm_addr),
    .id_rA_data(id_rA_data), .id_rB_data(id_rB_data),
    .mem_rD(mem_rD), .mem_wrEn(mem_wrEn), .wb_rD(wb_rD),
    .wb_wrEn(wb_wrEn), .wb_data(wb_data),
    .id_stall(s1), .id_br_taken(bt1), .id_br_target(tg1),
    .ex_valid(v1), .ex_op_code(op1), .ex_rD(rd1), .ex_wrEn(w1),
    .ex_memEn(m1), .ex_memwrEn(mw1), .ex_imm(im1),
    .ex_rA_data(ra1), .ex_rB_data(rb1),
    .ex_fwd_A(fa1), .ex_fwd_B(fb1)
  );

  id_hazard_stage #(.LOAD_LAT(3)) u3 (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_op_code(id_op_code), .id_rD(id_rD), .id_rA(id_rA),
    .id_rB(id_rB), .id_rA_used(id_rA_used), .id_rB_used(id_rB_used),
    .id_wrEn(id_wrEn), .id_memEn(id_memEn), .id_memwrEn(id_memwrEn),
    .id_bez(id_bez), .id_bnez(id_bnez), .id_imm_addr(id_imm_addr),
    .id_rA_data(id_rA_data), .id_rB_data(id_rB_data),
    .mem_rD(mem_rD), .mem_wrEn(mem_wrEn), .wb_rD(wb_rD),
    .wb_wrEn(wb_wrEn), .wb_data(wb_data),
    .id_stall(s3), .id_br_taken(bt3), .id_br_target(tg3),
    .ex_valid(v3), .ex_op_code(op3), .ex_rD(rd3), .ex_wrEn(w3),
    .ex_memEn(m3), .ex_memwrEn(mw3), .ex_imm(im3),
    .ex_rA_data(ra3), .ex_rB_data(rb3),
    .ex_fwd_A(fa3), .ex_fwd_B(fb3)
  );

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  // Monitor: every valid EX instruction must match the head of the queue.
  always @(negedge clk) begin
    logic vv;
    exp_t act, e;
    if (!reset && phase != 0) begin
      if (phase == 1) begin
        vv  = v1;
        act = {op1, rd1, w1, m1, mw1, im1, ra1, rb1, fa1, fb1};
      end else begin
        vv  = v3;
        act = {op3, rd3, w3, m3, mw3, im3, ra3, rb3, fa3, fb3};
      end
      if (vv) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL ex_unexpected actual=%h required=none", act);
        end else begin
          e = q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL ex_bundle actual=%h required=%h", act, e);
          end
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic clr;
    id_valid = 0; id_op_code = 0; id_rD = 0; id_rA = 0; id_rB = 0;
    id_rA_used = 0; id_rB_used = 0; id_wrEn = 0; id_memEn = 0;
    id_memwrEn = 0; id_bez = 0; id_bnez = 0; id_imm_addr = 0;
    id_rA_data = 0; id_rB_data = 0; mem_rD = 0; mem_wrEn = 0;
    wb_rD = 0; wb_wrEn = 0; wb_data = 0;
  endtask

  task automatic ins(input logic [5:0] op, input logic [4:0] rd,
                     input logic [4:0] ra, input logic [4:0] rb,
                     input logic ua, input logic ub, input logic w,
                     input logic m, input logic mw,
                     input logic [63:0] da, input logic [63:0] db);
    id_valid = 1; id_op_code = op; id_rD = rd; id_rA = ra; id_rB = rb;
    id_rA_used = ua; id_rB_used = ub; id_wrEn = w; id_memEn = m;
    id_memwrEn = mw; id_bez = 0; id_bnez = 0;
    id_imm_addr = {op, 10'h2A5}; id_rA_data = da; id_rB_data = db;
  endtask

  task automatic push(input logic [1:0] fa, input logic [1:0] fb);
    q.push_back({id_op_code, id_rD, id_wrEn, id_memEn, id_memwrEn,
                 id_imm_addr, id_rA_data, id_rB_data, fa, fb});
  endtask

  initial begin
    clr();
    reset = 1;
    step();
    // Reset with garbage on every input.
    id_valid = 1; id_op_code = 6'($urandom); id_rD = 5'($urandom);
    id_rA = 5'($urandom); id_rB = 5'($urandom); id_rA_used = 1;
    id_rB_used = 1; id_wrEn = 1; id_memEn = 1; id_memwrEn = 0;
    id_bez = 1; id_bnez = 1; id_imm_addr = 16'($urandom);
    id_rA_data = {$urandom, $urandom}; id_rB_data = {$urandom, $urandom};
    mem_rD = 5'($urandom); mem_wrEn = 1; wb_rD = 5'($urandom);
    wb_wrEn = 1; wb_data = {$urandom, $urandom};
    step();
    step();
    reset = 0;
    #1;
    chk("rst_ex_valid", {62'd0, v1, v3}, 0);
    chk("rst_ex_ctrl", {58'd0, w1, m1, mw1, w3, m3, mw3}, 0);
    chk("rst_ex_op_rd", {42'd0, op1, rd1, op3, rd3}, 0);
    chk("rst_ex_data", ra1 | rb1 | ra3 | rb3 | {32'd0, im1, im3}, 0);
    chk("rst_ex_fwd", {56'd0, fa1, fb1, fa3, fb3}, 0);
    chk("rst_stall", {62'd0, s1, s3}, 0);
    clr();
    phase = 1;

    // LOAD_LAT=1 load-use on rA.
    step();
    ins(6'd1, 5'd3, 5'd0, 5'd0, 0, 0, 1, 1, 0, 64'h11, 64'h22);
    push(2'b00, 2'b00);
    #1 chk("ld_no_stall", {63'd0, s1}, 0);
    step();
    ins(6'd2, 5'd4, 5'd3, 5'd5, 1, 1, 1, 0, 0, 64'hA, 64'hB);
    #1 chk("lu1_stall", {63'd0, s1}, 1);
    step();
    mem_rD = 5'd3; mem_wrEn = 1;
    push(2'b01, 2'b00);
    #1 chk("lu1_bubble", {63'd0, v1}, 0);
    chk("lu1_release", {63'd0, s1}, 0);

    // Forwarding priority.
    step();
    ins(6'd3, 5'd1, 5'd7, 5'd9, 1, 0, 1, 0, 0, 64'h31, 64'h32);
    mem_rD = 5'd7; mem_wrEn = 1; wb_rD = 5'd7; wb_wrEn = 1;
    push(2'b01, 2'b00);
    step();
    ins(6'd3, 5'd1, 5'd7, 5'd7, 1, 1, 1, 0, 0, 64'h33, 64'h34);
    mem_wrEn = 0;
    push(2'b10, 2'b10);
    step();
    ins(6'd3, 5'd1, 5'd7, 5'd7, 0, 0, 1, 0, 0, 64'h35, 64'h36);
    push(2'b00, 2'b00);

    // Branch hazard then WB bypass.
    step();
    clr();
    ins(6'd4, 5'd2, 5'd0, 5'd0, 0, 0, 1, 0, 0, 64'h41, 64'h42);
    push(2'b00, 2'b00);
    step();
    ins(6'd5, 5'd0, 5'd0, 5'd2, 0, 1, 0, 0, 0, 64'h0, 64'h0);
    id_bez = 1; id_imm_addr = 16'h1234;
    #1 chk("br_haz_stall", {63'd0, s1}, 1);
    chk("br_taken_masked", {63'd0, bt1}, 0);
    step();
    wb_rD = 5'd2; wb_wrEn = 1; wb_data = 64'd0; id_rB_data = 64'd9;
    push(2'b00, 2'b10);
    #1 chk("br_release", {63'd0, s1}, 0);
    chk("bez_taken_byp", {63'd0, bt1}, 1);
    chk("br_target", {48'd0, tg1}, 64'h1234);
    chk("br_bubble", {63'd0, v1}, 0);
    step();
    ins(6'd6, 5'd0, 5'd0, 5'd2, 0, 1, 0, 0, 0, 64'h0, 64'h0);
    id_bnez = 1; wb_rD = 5'd2; wb_wrEn = 1; wb_data = 64'd5;
    push(2'b00, 2'b10);
    #1 chk("bnez_taken_byp", {63'd0, bt1}, 1);
    step();
    wb_wrEn = 0;
    push(2'b00, 2'b00);
    #1 chk("bnez_not_taken", {63'd0, bt1}, 0);
    step();
    clr();
    #1 chk("idle_no_stall", {62'd0, s1, bt1}, 0);
    step();
    step();
    chk("q_empty_p1", 64'(q.size()), 0);

    // LOAD_LAT=3 instance.
    phase = 0;
    reset = 1;
    step();
    reset = 0;
    phase = 3;
    step();
    ins(6'd1, 5'd6, 5'd0, 5'd0, 0, 0, 1, 1, 0, 64'h5, 64'h6);
    push(2'b00, 2'b00);
    step();
    ins(6'd7, 5'd8, 5'd0, 5'd6, 0, 1, 1, 0, 0, 64'h7, 64'h8);
    #1 chk("lu3_stall_c1", {63'd0, s3}, 1);
    chk("lu3_br_off", {63'd0, bt3}, 0);
    for (int i = 2; i <= 3; i++) begin
      step();
      #1 chk($sformatf("lu3_stall_c%0d", i), {62'd0, s3, v3}, 2);
    end
    step();
    wb_rD = 5'd6; wb_wrEn = 1;
    push(2'b00, 2'b10);
    #1 chk("lu3_release", {62'd0, s3, v3}, 0);
    chk("lu3_target", {48'd0, tg3}, {48'd0, id_imm_addr});
    step();
    clr();

    // Reset during the second stall cycle.
    step();
    ins(6'd1, 5'd6, 5'd0, 5'd0, 0, 0, 1, 1, 0, 64'h51, 64'h52);
    push(2'b00, 2'b00);
    step();
    ins(6'd7, 5'd8, 5'd0, 5'd6, 0, 1, 1, 0, 0, 64'h53, 64'h54);
    #1 chk("rs_stall_c1", {63'd0, s3}, 1);
    step();
    reset = 1;
    #1 chk("rs_stall_in_reset", {63'd0, s3}, 0);
    step();
    reset = 0;
    push(2'b00, 2'b00);
    #1 chk("rs_no_carry", {62'd0, s3, v3}, 0);
    step();
    clr();
    #1 chk("rs_sub_in_ex", {63'd0, v3}, 1);
    step();
    step();
    chk("q_empty_p3", 64'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_hazard_stage.md
Name: id_hazard_stage

Overview:
- Parametrised successor to the decode stage. Takes pre-decoded fields and register-file read data for one instruction in ID.
- Detects load-use and branch-operand hazards and stalls IF/ID for a programmable number of cycles, inserting bubbles into EX.
- Computes 2-bit forwarding selects for both sources and resolves BEZ/BNEZ in ID.
- Owns the ID/EX pipeline register.

Parameters:
DATA_W, 64, register data width
RADDR_W, 5, register index width
IMM_W, 16, immediate/branch target width
OP_W, 6, opcode width
LOAD_LAT, 1, bubbles inserted on a load-use hazard (1..7)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_op_code  in  OP_W  opcode
id_rD, id_rA, id_rB  in  RADDR_W  destination/source indices (rB already muxed with rD for rD-as-source forms)
id_rA_used, id_rB_used  in  1  source actually read
id_wrEn, id_memEn, id_memwrEn  in  1  decoded controls; load = memEn & ~memwrEn
id_bez, id_bnez  in  1  branch type
id_imm_addr  in  IMM_W  immediate / branch target
id_rA_data, id_rB_data  in  DATA_W  register-file read data
mem_rD  in  RADDR_W  EX/MEM destination
mem_wrEn  in  1  EX/MEM writes
wb_rD  in  RADDR_W  MEM/WB destination
wb_wrEn  in  1  MEM/WB writes
id_stall  out  1  hold PC and IF/ID
id_br_taken  out  1  branch taken: IF flush / PC select
id_br_target  out  IMM_W  = id_imm_addr
ex_valid  out  1  EX holds a real instruction
ex_op_code  out  OP_W  registered opcode
ex_rD  out  RADDR_W  registered destination
ex_wrEn, ex_memEn, ex_memwrEn  out  1  registered controls (0 in a bubble)
ex_imm  out  IMM_W  registered immediate
ex_rA_data, ex_rB_data  out  DATA_W  registered operands
ex_fwd_A, ex_fwd_B  out  2  00 = RF, 01 = EX/MEM, 10 = MEM/WB

Behaviour:
- Reset (sync, active-high):
  - All ex_* outputs go to 0, including ex_valid = 0 and fwd = 00.
  - FSM goes to RUN and the stall counter to 0.
  - id_stall and id_br_taken are 0 during reset and the following cycle, unless a hazard condition is met.
  - Reset mid-stall abandons the stall with no carry-over.
- Hazards:
  - Load-use: ex_valid & ex_memEn & ~ex_memwrEn & ex_wrEn & id_valid & ((id_rA_used & id_rA==ex_rD) | (id_rB_used & id_rB==ex_rD)).
  - Branch hazard: id_valid & (id_bez|id_bnez) & ex_valid & ex_wrEn & id_rB==ex_rD. The branch compares rB in ID, so EX results are not yet usable.
- FSM states:
  - RUN:
    - On load-use, assert id_stall, load cnt = LOAD_LAT-1, insert bubble (ex_valid = 0, ex_wrEn/memEn/memwrEn = 0, other ex_* don't-care), and go to STALL if LOAD_LAT>1, else stay in RUN.
    - On branch hazard (no load-use), assert id_stall for 1 cycle and insert a bubble.
    - Otherwise advance ID to EX.
  - STALL: id_stall=1, bubble, cnt decrements; at cnt==0 return to RUN next cycle.
- Load-use and branch hazard together: load-use wins. Its count covers the branch, because the RUN re-check repeats until no hazard remains.
- Forwarding select for a source s with index r, computed on the cycle the instruction leaves ID and registered with it:
  - 01 if mem_wrEn & mem_rD==r.
  - Else 10 if wb_wrEn & wb_rD==r.
  - Else 00.
  - Unused source gives 00. EX/MEM has priority. All registers, including r0, are ordinary.
- Branch:
  - Evaluated only when id_valid & ~id_stall.
  - Taken = (id_bez & rBv==0) | (id_bnez & rBv!=0), where rBv is id_rB_data, or the MEM/WB result if wb_wrEn & wb_rD==id_rB.
  - A WB-to-ID bypass is provided: wb_rD_data arrives as input wb_data (DATA_W) appended to the port list after wb_wrEn.
  - id_br_taken is combinational. The branch itself enters EX as a valid non-writing instruction.
- Stall priority: while id_stall=1, id_br_taken = 0.
- id_valid=0 gives a bubble, no hazards and no stall.
- Latency: 1 cycle ID to EX without hazard; 1+LOAD_LAT cycles on load-use.

Test Plan:
- Reset with garbage inputs, then release → all ex_* = 0 and id_stall = 0 on the first cycle after reset.
- LD r3 then ADD r4,r3,r5 with LOAD_LAT=1 → id_stall high 1 cycle, one bubble (ex_valid=0), ADD reaches EX with ex_fwd_A=01 (r3 now in EX/MEM).
- LOAD_LAT=3, load-use on rB → id_stall high exactly 3 cycles, 3 bubbles, then ex_fwd_B=00/10 per mem/wb indices.
- mem_rD=7 and wb_rD=7 both writing, id_rA=7 used → ex_fwd_A=01. With only wb writing → 10. With id_rA_used=0 → 00.
- ADD r2 in EX, then BEZ r2 → 1-cycle stall. Next cycle wb_rD=2, wb_data=0 → id_br_taken=1, id_br_target=id_imm_addr. With wb_data=5 and BNEZ → taken.
- Reset asserted in the 2nd cycle of a LOAD_LAT=3 stall → id_stall 0 after reset, FSM in RUN, no residual bubble.
